// File: rtl/mod_sq_pkg.sv
// mod_sq_pkg: shared widths and shift encodings for the magnitude-squared
// integrator.
//   sw_width  - width of one per-sample power term after the FRAC truncation
//   aw_width  - accumulator width, wide enough for 2^CNT_W power terms
//   shift_e   - encoding of cfg_shift (right shift of 0/4/8/12 bits)
package mod_sq_pkg;

   typedef enum logic [1:0] {
      SHIFT_0  = 2'd0,
      SHIFT_4  = 2'd1,
      SHIFT_8  = 2'd2,
      SHIFT_12 = 2'd3
   } shift_e;

   // I^2 + Q^2 needs 2*in_w+1 bits; the FRAC truncation drops frac of them.
   function automatic int sw_width(input int in_w, input int frac);
      return 2 * in_w + 1 - frac;
   endfunction

   function automatic int aw_width(input int in_w, input int frac, input int cnt_w);
      return sw_width(in_w, frac) + cnt_w;
   endfunction

endpackage

// File: rtl/mod_sq_sat_shift.sv
// mod_sq_sat_shift: combinational precision shift plus saturation.
//   acc   in  AW     integrated power
//   shift in  2      right shift of 4*shift bits
//   data  out OUT_W  shifted value, all ones when it does not fit
//   sat   out 1      data was clipped
module mod_sq_sat_shift
   import mod_sq_pkg::*;
#(
   parameter int AW    = 33,
   parameter int OUT_W = 24
) (
   input  logic [AW-1:0]    acc,
   input  logic [1:0]       shift,
   output logic [OUT_W-1:0] data,
   output logic             sat
);

   logic [AW-1:0] r;

   always_comb begin
      r = acc;
      case (shift_e'(shift))
         SHIFT_0:  r = acc;
         SHIFT_4:  r = acc >> 4;
         SHIFT_8:  r = acc >> 8;
         SHIFT_12: r = acc >> 12;
         default:  r = acc;
      endcase
   end

   always_comb begin
      data = r[OUT_W-1:0];
      sat  = 1'b0;
      // Any set bit above OUT_W means R >= 2^OUT_W.
      if (|r[AW-1:OUT_W]) begin
         data = '1;
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/mod_squared_integ.sv
// mod_squared_integ: pipelined |I|^2+|Q|^2 with non-coherent integration over
// cfg_int_len+1 samples, precision shift and saturation, valid/ready output.
//   clk, rst          clock, asynchronous active-high reset
//   cfg_int_len       window length minus one, latched at window start
//   cfg_shift         output shift (4*cfg_shift bits), latched at window start
//   s_valid/s_ready   input handshake; s_i, s_q signed samples
//   m_valid/m_ready   output handshake; m_data power, m_sat clip flag
// Pipeline: S1 squares, S2 sum/truncate, S3 accumulate + output register.
// All stages advance together on en = !m_valid || m_ready.
module mod_squared_integ
   import mod_sq_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int FRAC  = 4,
   parameter int CNT_W = 4,
   parameter int OUT_W = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       cfg_int_len,
   input  logic [1:0]             cfg_shift,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic signed [IN_W-1:0] s_i,
   input  logic signed [IN_W-1:0] s_q,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [OUT_W-1:0]       m_data,
   output logic                   m_sat
);

   localparam int SW = sw_width(IN_W, FRAC);
   localparam int AW = aw_width(IN_W, FRAC, CNT_W);

   logic                   en;
   logic signed [2*IN_W-1:0] i_ext, q_ext;

   logic                   v1, v2;
   logic [2*IN_W-1:0]      sq_i, sq_q;
   logic [SW-1:0]          p;

   logic [AW-1:0]          acc;
   logic [CNT_W-1:0]       cnt, len_l;
   logic [1:0]             shift_l;

   logic                   first, last;
   logic [CNT_W-1:0]       eff_len;
   logic [1:0]             eff_shift;
   logic [AW-1:0]          total;
   logic [OUT_W-1:0]       res_data;
   logic                   res_sat;

   assign en      = !m_valid || m_ready;
   assign s_ready = en;

   // Full-width signed operands; the square of -2^(IN_W-1) is exact in 2*IN_W bits.
   assign i_ext = {{IN_W{s_i[IN_W-1]}}, s_i};
   assign q_ext = {{IN_W{s_q[IN_W-1]}}, s_q};

   // The first sample of a window uses live cfg values, so the window
   // closing decision is correct even when cfg_int_len is 0.
   always_comb begin
      first     = (cnt == '0);
      eff_len   = first ? cfg_int_len : len_l;
      eff_shift = first ? cfg_shift   : shift_l;
      last      = (cnt == eff_len);
      total     = acc + {{(AW-SW){1'b0}}, p};
   end

   mod_sq_sat_shift #(
      .AW    (AW),
      .OUT_W (OUT_W)
   ) u_sat_shift (
      .acc   (total),
      .shift (eff_shift),
      .data  (res_data),
      .sat   (res_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         sq_i    <= '0;
         sq_q    <= '0;
         p       <= '0;
         acc     <= '0;
         cnt     <= '0;
         len_l   <= '0;
         shift_l <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sat   <= 1'b0;
      end else if (en) begin
         // S1
         v1   <= s_valid;
         sq_i <= i_ext * i_ext;
         sq_q <= q_ext * q_ext;
         // S2
         v2 <= v1;
         p  <= SW'(({1'b0, sq_i} + {1'b0, sq_q}) >> FRAC);
         // S3: handshake clears, a same-cycle load below keeps m_valid high
         if (m_ready) m_valid <= 1'b0;
         if (v2) begin
            if (first) begin
               len_l   <= cfg_int_len;
               shift_l <= cfg_shift;
            end
            if (last) begin
               m_valid <= 1'b1;
               m_data  <= res_data;
               m_sat   <= res_sat;
               acc     <= '0;
               cnt     <= '0;
            end else begin
               acc <= total;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mod_squared_integ.sv
module tb_mod_squared_integ;

   localparam int IN_W  = 16;
   localparam int FRAC  = 4;
   localparam int CNT_W = 4;
   localparam int OUT_W = 24;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [CNT_W-1:0]       cfg_int_len;
   logic [1:0]             cfg_shift;
   logic                   s_valid;
   logic                   s_ready;
   logic signed [IN_W-1:0] s_i, s_q;
   logic                   m_valid;
   logic                   m_ready;
   logic [OUT_W-1:0]       m_data;
   logic                   m_sat;

   always #5 clk = ~clk;

   mod_squared_integ #(
      .IN_W  (IN_W),
      .FRAC  (FRAC),
      .CNT_W (CNT_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_int_len (cfg_int_len),
      .cfg_shift   (cfg_shift),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_i         (s_i),
      .s_q         (s_q),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_sat       (m_sat)
   );

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             sat;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   results  = 0;
   bit   bp_en    = 0;

   // Reference: window state tracked per accepted sample, cfg taken at the
   // acceptance of a window's first sample (bench keeps cfg stable around it).
   longint acc_m = 0;
   int     cnt_m = 0;
   int     len_m = 0;
   int     sh_m  = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_accept(input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
      longint li, lq, pw, r, maxv;
      exp_t   e;
      li   = i;
      lq   = q;
      pw   = (li * li + lq * lq) / (64'sd1 << FRAC);
      maxv = (64'sd1 << OUT_W) - 1;
      if (cnt_m == 0) begin
         len_m = int'(cfg_int_len);
         sh_m  = int'(cfg_shift);
      end
      acc_m += pw;
      if (cnt_m == len_m) begin
         r = acc_m / (64'sd1 << (4 * sh_m));
         if (r > maxv) begin
            e.data = '1;
            e.sat  = 1'b1;
         end else begin
            e.data = OUT_W'(r);
            e.sat  = 1'b0;
         end
         exp_q.push_back(e);
         acc_m = 0;
         cnt_m = 0;
      end else begin
         cnt_m++;
      end
   endtask

   // Monitor: compare on each output handshake, check hold during stalls.
   logic             prev_stall = 1'b0;
   logic [OUT_W-1:0] prev_data;
   logic             prev_sat;
   exp_t             got;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", longint'(m_valid), 1);
            check("hold_data", longint'(m_data), longint'(prev_data));
            check("hold_sat", longint'(m_sat), longint'(prev_sat));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result actual=%0h required=none", m_data);
            end else begin
               got = exp_q.pop_front();
               check("result_data", longint'(m_data), longint'(got.data));
               check("result_sat", longint'(m_sat), longint'(got.sat));
               results++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_sat   = m_sat;
      end
   end

   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q);
      int budget;
      bit done;
      budget  = 200;
      done    = 0;
      s_valid = 1'b1;
      s_i     = i;
      s_q     = q;
      while (!done && budget > 0) begin
         @(negedge clk);
         if (s_ready) done = 1;
         budget--;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      if (done) model_accept(i, q);
      else begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=0 required=1");
      end
   endtask

   task automatic drain();
      int budget;
      bp_en = 0;
      @(posedge clk);
      #2;
      m_ready = 1'b1;
      budget  = 300;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
      idle(3);
   endtask

   int r0;

   initial begin
      rst = 1'b1; cfg_int_len = '0; cfg_shift = '0;
      s_valid = 1'b0; s_i = '0; s_q = '0; m_ready = 1'b1;
      idle(2);
      @(negedge clk);
      check("reset_m_valid", longint'(m_valid), 0);
      check("reset_m_data", longint'(m_data), 0);
      check("reset_m_sat", longint'(m_sat), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_s_ready", longint'(s_ready), 1);
      @(posedge clk); #1;

      // Single sample, latency and value 1.0 -> 16
      send(16, 0);
      @(negedge clk); check("latency_n", longint'(m_valid), 0);
      @(negedge clk); check("latency_n1", longint'(m_valid), 0);
      @(negedge clk); check("latency_n2", longint'(m_valid), 1);
      check("latency_data", longint'(m_data), 16);
      drain();

      // Most-negative operands: saturate at shift 0, exact at shift 3
      send(-32768, -32768);
      drain();
      cfg_shift = 2'd3;
      send(-32768, -32768);
      drain();
      cfg_shift = 2'd0;

      // Window of 4: 12 samples -> 3 results of 128
      cfg_int_len = 4'd3;
      r0 = results;
      for (int k = 0; k < 12; k++) send(16, 16);
      drain();
      check("window_count", results - r0, 3);

      // Continuous stream with 5-cycle downstream stall
      cfg_int_len = 4'd0;
      r0 = results;
      fork
         begin
            for (int k = 0; k < 12; k++) send(16'(k * 37 - 200), 16'(k * 11));
         end
         begin
            idle(4);
            m_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_s_ready", longint'(s_ready), 0);
            end
            @(posedge clk); #1;
            m_ready = 1'b1;
         end
      join
      drain();
      check("stall_count", results - r0, 12);

      // Length change mid-window takes effect at the next window
      cfg_int_len = 4'd3;
      r0 = results;
      send(16, 16); send(16, 16);
      idle(3);
      cfg_int_len = 4'd0;
      send(16, 16); send(16, 16);
      for (int k = 0; k < 3; k++) send(16, 0);
      drain();
      check("cfg_change_count", results - r0, 4);

      // Reset mid-window discards the partial sum
      cfg_int_len = 4'd3;
      send(16, 16); send(16, 16);
      idle(3);
      rst = 1'b1;
      @(negedge clk);
      check("rst_during_valid", longint'(m_valid), 0);
      idle(2);
      rst   = 1'b0;
      acc_m = 0;
      cnt_m = 0;
      @(negedge clk);
      check("rst_after_valid", longint'(m_valid), 0);
      @(posedge clk); #1;
      r0 = results;
      for (int k = 0; k < 4; k++) send(16, 16);
      drain();
      check("rst_window_count", results - r0, 1);

      // Randomised phases with random backpressure and input gaps
      for (int ph = 0; ph < 4; ph++) begin
         int n;
         logic signed [IN_W-1:0] vi, vq;
         cfg_int_len = CNT_W'($urandom_range(0, 15));
         cfg_shift   = 2'($urandom_range(0, 3));
         n = (int'(cfg_int_len) + 1) * 3;
         bp_en = 1;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               vi = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7FFF;
               vq = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7FFF;
            end else begin
               vi = 16'($urandom);
               vq = 16'($urandom >> 7);
            end
            send(vi, vq);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
         drain();
      end

      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
